mux2_rr_arbiter: RTL and testbench
==================================

# mux2_rr_arbiter

Two-channel round-robin arbiter with a one-entry registered output stage. It sits directly upstream of `mux2to1`, the datapath mux. It chooses which of two valid/ready producers is forwarded, drives the select for that mux, and registers the chosen word so the downstream consumer sees a clean valid/ready channel. It also counts accepted transfers per source for debug and observability.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of every data bus.
- `CNT_WIDTH`, default 8: width of each per-source transfer counter.

Ports:
- `i_clk`, input, 1: single clock; everything is sampled on the rising edge.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_a_valid`, input, 1: source A offers a word.
- `i_a_data`, input, `DATA_WIDTH`: source A data.
- `o_a_ready`, output, 1: source A word is accepted this cycle.
- `i_b_valid`, input, 1: source B offers a word.
- `i_b_data`, input, `DATA_WIDTH`: source B data.
- `o_b_ready`, output, 1: source B word is accepted this cycle.
- `o_sel`, output, 1: mux select for the current grant; 0 = A, 1 = B. This matches `mux2to1`, where `i_sel`=0 selects `i_a`.
- `o_valid`, output, 1: the output register holds a word.
- `o_data`, output, `DATA_WIDTH`: registered output word.
- `o_src`, output, 1: source of the word in `o_data` (0 = A, 1 = B).
- `i_ready`, input, 1: downstream accepts `o_data` this cycle.
- `o_cnt_a`, output, `CNT_WIDTH`: number of accepted A transfers.
- `o_cnt_b`, output, `CNT_WIDTH`: number of accepted B transfers.

## Operation
- **Internal mux.** The datapath instantiates one `mux2to1` (`DATA_WIDTH`) fed by `i_a_data`, `i_b_data` and `o_sel`. Its output is the D input of the output register.
- **Load enable.** `load_en = !o_valid || i_ready`: the register is empty or is being drained this cycle.
- **Priority pointer.** One-bit `prio` (0 = A preferred). It is the only arbitration state.
- **Grant (combinational, from the valids and `prio`):**
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source `prio` names.
  - Neither valid: no grant; `o_sel` holds its last registered value.
- **Readys.** `o_a_ready = load_en && grant_A`; `o_b_ready = load_en && grant_B`.
  - The two readys are never high together.
  - Readys may depend combinationally on `i_*_valid` and `i_ready`.
  - Producers must not make a valid depend on its ready.
- **On accept (a ready and its valid both high):**
  - The register loads the muxed data; `o_src` is set to the granted source; `o_valid` is set to 1.
  - `prio` becomes the other source, even if that source is idle.
  - The granted source's counter increments, wrapping from 2^`CNT_WIDTH`-1 to 0.
- **Drain with no accept.** `o_valid && i_ready` with no accept clears `o_valid`; `o_data` and `o_src` keep their old values.
- **Drain and accept in the same cycle.** The new word replaces the old one and `o_valid` stays 1. This gives a throughput of one word per cycle.
- **Stall.** While `o_valid && !i_ready`, both readys are 0 and `o_data`, `o_src`, `prio` and the counters all hold.
- **Output stability.** While `o_valid` is 1, `o_data` and `o_src` change only on a cycle where `i_ready` is 1.
- **Reset** (synchronous, overrides everything in that cycle):
  - `o_valid`=0, `o_data`=0, `o_src`=0, `o_sel`=0, `prio`=0, `o_cnt_a`=0, `o_cnt_b`=0.
  - `o_a_ready`=0 and `o_b_ready`=0 during reset.
  - Reset in the middle of a stall discards the held word; `o_valid` falls on the next edge.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears with `o_valid`=1 after edge N.
- Arbitration state updates only on accepts. A stalled cycle never rotates `prio`.
- `o_sel` reflects the current-cycle grant. It is combinational and glitch-tolerant only within the cycle. When there is no grant it is driven from a register holding the last grant.
- There is no combinational path from `i_*_data` to `o_data`.

## Test plan
- **Reset.** Assert `i_rst` for 2 cycles with both sources valid. Required: `o_valid`=0, readys=0 and counts=0 throughout; the first post-reset accept is A.
- **Contention.** Hold both sources valid (A=0x11, B=0x22) with `i_ready`=1 for 6 cycles. Required: output sequence A, B, A, B, A, B with one word per cycle and `o_cnt_a`=`o_cnt_b`=3.
- **Backpressure.** Send A=0x5A, then drop `i_ready` for 4 cycles with B valid. Required: `o_data` holds 0x5A, `o_b_ready`=0 and `prio` is unchanged; B=0xB5 appears one cycle after `i_ready` rises.
- **Single source.** Keep only B valid for 5 consecutive words. Required: all 5 are granted back-to-back with no bubbles, then A wins the next contended cycle.
- **Counter wrap.** With `CNT_WIDTH`=4, send 17 A transfers. Required: `o_cnt_a`=1 and `o_cnt_b`=0.
- **Reset mid-stall.** Hold `o_valid`=1 with `i_ready`=0, then assert `i_rst`. Required: `o_valid`=0 and `o_data`=0 after the edge, and no word is delivered.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// Drives the select of the downstream mux2to1 and counts accepted transfers per source.

module mux2to1 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_sel,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module mux2_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_valid,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic                  o_a_ready,
    input  logic                  i_b_valid,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_b_ready,
    output logic                  o_sel,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_src,
    input  logic                  i_ready,
    output logic [CNT_WIDTH-1:0]  o_cnt_a,
    output logic [CNT_WIDTH-1:0]  o_cnt_b
);
    logic                  w_load_en;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_sel;
    logic                  w_acc_a;
    logic                  w_acc_b;
    logic [DATA_WIDTH-1:0] w_mux;

    logic                  r_prio;
    logic                  r_sel;
    logic                  r_valid;
    logic                  r_src;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]  r_cnt_a;
    logic [CNT_WIDTH-1:0]  r_cnt_b;

    assign w_load_en = !r_valid || i_ready;

    // Grant from the valids; prio only breaks ties.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        case ({i_a_valid, i_b_valid})
            2'b10: w_gnt_a = 1'b1;
            2'b01: w_gnt_b = 1'b1;
            2'b11: begin
                if (r_prio) begin
                    w_gnt_b = 1'b1;
                end else begin
                    w_gnt_a = 1'b1;
                end
            end
            default: begin
                w_gnt_a = 1'b0;
                w_gnt_b = 1'b0;
            end
        endcase
    end

    // Select follows the live grant; with no grant it replays the last one.
    always_comb begin
        w_sel = 1'b0;
        if (i_rst) begin
            w_sel = 1'b0;
        end else if (w_gnt_a || w_gnt_b) begin
            w_sel = w_gnt_b;
        end else begin
            w_sel = r_sel;
        end
    end

    assign o_a_ready = !i_rst && w_load_en && w_gnt_a;
    assign o_b_ready = !i_rst && w_load_en && w_gnt_b;
    assign w_acc_a   = o_a_ready && i_a_valid;
    assign w_acc_b   = o_b_ready && i_b_valid;
    assign o_sel     = w_sel;

    mux2to1 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .i_sel (w_sel),
        .i_a   (i_a_data),
        .i_b   (i_b_data),
        .o_y   (w_mux)
    );

    // Output register, arbitration pointer and per-source counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio  <= 1'b0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
            r_src   <= 1'b0;
            r_data  <= {DATA_WIDTH{1'b0}};
            r_cnt_a <= {CNT_WIDTH{1'b0}};
            r_cnt_b <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_gnt_a || w_gnt_b) begin
                r_sel <= w_gnt_b;
            end
            if (w_acc_a || w_acc_b) begin
                r_data  <= w_mux;
                r_src   <= w_acc_b;
                r_valid <= 1'b1;
                // Rotate to the other source even if it is idle.
                r_prio  <= w_acc_a;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_acc_a) begin
                r_cnt_a <= r_cnt_a + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_acc_b) begin
                r_cnt_b <= r_cnt_b + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;
    assign o_cnt_a = r_cnt_a;
    assign o_cnt_b = r_cnt_b;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a reference model pushes accepted words,
// which are popped and compared when the DUT hands them downstream.

module tb_mux2_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       ready = 1'b0;
    logic       o_a_ready, o_b_ready, o_sel, o_valid, o_src;
    logic [7:0] o_data;
    logic [3:0] o_cnt_a, o_cnt_b;

    int checks = 0;
    int failures = 0;

    logic       m_valid = 1'b0;
    logic       m_prio = 1'b0;
    logic [3:0] m_cnt_a = 4'd0;
    logic [3:0] m_cnt_b = 4'd0;
    logic       e_load, e_ga, e_gb, e_ar, e_br;
    logic [8:0] exp_q[$];
    logic [8:0] got_w, exp_w;

    mux2_rr_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(o_a_ready),
        .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(o_b_ready),
        .o_sel(o_sel), .o_valid(o_valid), .o_data(o_data), .o_src(o_src),
        .i_ready(ready), .o_cnt_a(o_cnt_a), .o_cnt_b(o_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic model_comb();
        e_load = !m_valid || ready;
        e_ga   = a_valid && (!b_valid || !m_prio);
        e_gb   = b_valid && (!a_valid || m_prio);
        e_ar   = !rst && e_load && e_ga;
        e_br   = !rst && e_load && e_gb;
    endtask

    // Advance one clock and update the reference model; accepted words go to the scoreboard.
    task automatic tick();
        model_comb();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_prio = 1'b0; m_cnt_a = 4'd0; m_cnt_b = 4'd0;
            exp_q.delete();
        end else if (e_ar || e_br) begin
            exp_q.push_back(e_ar ? {1'b0, a_data} : {1'b1, b_data});
            m_valid = 1'b1;
            m_prio  = e_ar;
            if (e_ar) m_cnt_a = m_cnt_a + 4'd1;
            else      m_cnt_b = m_cnt_b + 4'd1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0 || o_valid !== 1'b0 || o_cnt_a !== 4'd0 || o_cnt_b !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got rdy=%b%b v=%b cnt=%0d/%0d exp 00 0 0/0", i, o_a_ready, o_b_ready, o_valid, o_cnt_a, o_cnt_b);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_a_ready !== 1'b1 || o_b_ready !== 1'b0 || o_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant got rdy=%b%b sel=%b exp 10 sel=0", o_a_ready, o_b_ready, o_sel);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_src !== 1'b0 || o_data !== 8'h11) begin
            failures++;
            $display("FAIL reset_first_word got v=%b src=%b data=%h exp 1 0 11", o_valid, o_src, o_data);
        end
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        a_data = 8'h11; b_data = 8'h22; ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_valid = (i < 6); b_valid = (i < 6);
            #1;
            model_comb();
            checks++;
            if (o_a_ready !== e_ar || o_b_ready !== e_br || o_valid !== m_valid || o_cnt_a !== m_cnt_a || o_cnt_b !== m_cnt_b) begin
                failures++;
                $display("FAIL contention_state cyc=%0d got rdy=%b%b v=%b cnt=%0d/%0d exp %b%b %b %0d/%0d", i, o_a_ready, o_b_ready, o_valid, o_cnt_a, o_cnt_b, e_ar, e_br, m_valid, m_cnt_a, m_cnt_b);
            end
            if (i < 6) begin
                checks++;
                if (o_sel !== 1'(i % 2)) begin
                    failures++;
                    $display("FAIL contention_sel cyc=%0d got=%b exp=%b", i, o_sel, 1'(i % 2));
                end
            end
            if (m_valid && ready) begin
                checks++;
                got_w = {o_src, o_data};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL contention_word cyc=%0d got=%h exp=<empty>", i, got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        failures++;
                        $display("FAIL contention_word cyc=%0d got=%h exp=%h", i, got_w, exp_w);
                    end
                end
            end
            tick();
        end
        #1;
        checks++;
        if (o_cnt_a !== 4'd3 || o_cnt_b !== 4'd3) begin
            failures++;
            $display("FAIL contention_counts got=%0d/%0d exp=3/3", o_cnt_a, o_cnt_b);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            a_valid = (i == 0); a_data = 8'h5A;
            b_valid = (i >= 1 && i <= 5); b_data = 8'hB5;
            ready = !(i >= 1 && i <= 4);
            #1;
            model_comb();
            checks++;
            if (o_a_ready !== e_ar || o_b_ready !== e_br || o_valid !== m_valid || o_cnt_a !== m_cnt_a || o_cnt_b !== m_cnt_b) begin
                failures++;
                $display("FAIL backpressure_state cyc=%0d got rdy=%b%b v=%b cnt=%0d/%0d exp %b%b %b %0d/%0d", i, o_a_ready, o_b_ready, o_valid, o_cnt_a, o_cnt_b, e_ar, e_br, m_valid, m_cnt_a, m_cnt_b);
            end
            if (i >= 1 && i <= 5) begin
                checks++;
                if (o_data !== 8'h5A || o_b_ready !== (i == 5)) begin
                    failures++;
                    $display("FAIL backpressure_hold cyc=%0d got data=%h b_rdy=%b exp 5a %b", i, o_data, o_b_ready, (i == 5));
                end
            end
            if (i == 6) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== 8'hB5 || o_src !== 1'b1) begin
                    failures++;
                    $display("FAIL backpressure_b got v=%b data=%h src=%b exp 1 b5 1", o_valid, o_data, o_src);
                end
            end
            if (m_valid && ready) begin
                checks++;
                got_w = {o_src, o_data};
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL backpressure_word cyc=%0d got=%h exp=%h", i, got_w, exp_w);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_source();
        apply_reset();
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_valid = (i < 6); b_data = 8'h30 + 8'(i);
            a_valid = (i == 5); a_data = 8'hA5;
            #1;
            model_comb();
            checks++;
            if (o_a_ready !== e_ar || o_b_ready !== e_br || o_valid !== m_valid || o_cnt_a !== m_cnt_a || o_cnt_b !== m_cnt_b) begin
                failures++;
                $display("FAIL single_state cyc=%0d got rdy=%b%b v=%b cnt=%0d/%0d exp %b%b %b %0d/%0d", i, o_a_ready, o_b_ready, o_valid, o_cnt_a, o_cnt_b, e_ar, e_br, m_valid, m_cnt_a, m_cnt_b);
            end
            if (i < 6) begin
                checks++;
                if (o_a_ready !== (i == 5) || o_b_ready !== (i < 5)) begin
                    failures++;
                    $display("FAIL single_grant cyc=%0d got rdy=%b%b exp %b%b", i, o_a_ready, o_b_ready, (i == 5), (i < 5));
                end
            end
            if (m_valid && ready) begin
                checks++;
                got_w = {o_src, o_data};
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL single_word cyc=%0d got=%h exp=%h", i, got_w, exp_w);
                end
            end
            tick();
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        ready = 1'b1; b_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            a_valid = (i < 17); a_data = 8'(i);
            #1;
            if (m_valid && ready) begin
                checks++;
                got_w = {o_src, o_data};
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL wrap_word cyc=%0d got=%h exp=%h", i, got_w, exp_w);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (o_cnt_a !== 4'd1 || o_cnt_b !== 4'd0) begin
            failures++;
            $display("FAIL wrap_counts got=%0d/%0d exp=1/0", o_cnt_a, o_cnt_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            a_valid = (i == 0); a_data = 8'h77; b_valid = 1'b0;
            ready = (i == 0) || (i >= 4);
            rst = (i == 3);
            #1;
            model_comb();
            checks++;
            if (o_a_ready !== e_ar || o_b_ready !== e_br || o_valid !== m_valid || o_cnt_a !== m_cnt_a || o_cnt_b !== m_cnt_b) begin
                failures++;
                $display("FAIL midstall_state cyc=%0d got rdy=%b%b v=%b cnt=%0d/%0d exp %b%b %b %0d/%0d", i, o_a_ready, o_b_ready, o_valid, o_cnt_a, o_cnt_b, e_ar, e_br, m_valid, m_cnt_a, m_cnt_b);
            end
            if (i >= 4) begin
                checks++;
                if (o_valid !== 1'b0 || o_data !== 8'h00) begin
                    failures++;
                    $display("FAIL midstall_cleared cyc=%0d got v=%b data=%h exp 0 00", i, o_valid, o_data);
                end
            end
            if (m_valid && ready) begin
                checks++;
                got_w = {o_src, o_data};
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL midstall_word cyc=%0d got=%h exp=%h", i, got_w, exp_w);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_contention();
        test_backpressure();
        test_single_source();
        test_counter_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
